// File: rtl/wired_dispatch_pkg.sv
// rtl/wired_dispatch_pkg.sv - shared types, constants and lane helpers for the dispatch stage
package wired_dispatch_pkg;

  localparam int ROB_LEN_P = 6;
  localparam int DATA_W_P  = 32;
  localparam int FU_CNT_P  = 4;
  localparam int FU_ALU    = 0;

  typedef struct packed {
    logic [1:0][ROB_LEN_P-1:0] tag;
    logic [1:0]                opv;
    logic [1:0][DATA_W_P-1:0]  opd;
    logic [1:0]                scyc;
    logic [FU_CNT_P-1:0]       fu;
    logic                      excp;
  } disp_slot_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_LEN_P-1:0] wid;
    logic [DATA_W_P-1:0]  wdata;
  } cdb_lane_t;

  // Number of tag bits that select a CDB bank; a single lane needs none.
  function automatic int lane_bits(int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Bank a tag is broadcast on; n is a power of two.
  function automatic int lane_index(logic [ROB_LEN_P-1:0] tag, int n);
    return (n <= 1) ? 0 : (int'(tag) % n);
  endfunction

endpackage

// File: rtl/wired_dispatch_stage_if.sv
// rtl/wired_dispatch_stage_if.sv - rename/ROB/CDB/issue-queue signal bundle for the dispatch stage
interface wired_dispatch_stage_if #(
  parameter int WIDTH   = 2,
  parameter int CDB_CNT = 2,
  parameter int FU_CNT  = 4,
  parameter int ROB_LEN = 6,
  parameter int DATA_W  = 32
);
  logic [WIDTH-1:0]            r_valid_i;
  logic                        r_ready_o;
  logic [WIDTH*2*ROB_LEN-1:0]  r_tag_i;
  logic [WIDTH*2-1:0]          r_opv_i;
  logic [WIDTH*2*DATA_W-1:0]   r_opd_i;
  logic [WIDTH*2-1:0]          r_scyc_i;
  logic [WIDTH*FU_CNT-1:0]     r_fu_i;
  logic [WIDTH-1:0]            r_excp_i;
  logic [WIDTH*2-1:0]          rob_v_i;
  logic [WIDTH*2*DATA_W-1:0]   rob_d_i;
  logic [CDB_CNT-1:0]          cdb_valid_i;
  logic [CDB_CNT*ROB_LEN-1:0]  cdb_wid_i;
  logic [CDB_CNT*DATA_W-1:0]   cdb_wdata_i;
  logic [FU_CNT-1:0]           fu_ready_i;
  logic [WIDTH*FU_CNT-1:0]     fu_valid_o;
  logic [WIDTH-1:0]            rob_we_o;
  logic [WIDTH*2-1:0]          p_opv_o;
  logic [WIDTH*2*DATA_W-1:0]   p_opd_o;
  logic [WIDTH*2*ROB_LEN-1:0]  p_tag_o;

  modport master (
    output r_valid_i, r_tag_i, r_opv_i, r_opd_i, r_scyc_i, r_fu_i, r_excp_i,
    output rob_v_i, rob_d_i, cdb_valid_i, cdb_wid_i, cdb_wdata_i, fu_ready_i,
    input  r_ready_o, fu_valid_o, rob_we_o, p_opv_o, p_opd_o, p_tag_o
  );

  modport slave (
    input  r_valid_i, r_tag_i, r_opv_i, r_opd_i, r_scyc_i, r_fu_i, r_excp_i,
    input  rob_v_i, rob_d_i, cdb_valid_i, cdb_wid_i, cdb_wdata_i, fu_ready_i,
    output r_ready_o, fu_valid_o, rob_we_o, p_opv_o, p_opd_o, p_tag_o
  );
endinterface

// File: rtl/wired_dispatch_fwd.sv
// rtl/wired_dispatch_fwd.sv - per-operand late-operand capture from ROB read data and CDB (WIRED_DISPATCH_CDB_BANKED_EN selects banked lane compare)
import wired_dispatch_pkg::*;

module wired_dispatch_fwd #(
  parameter int CDB_CNT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          live,
  input  logic                          opv_q,
  input  logic                          scyc_q,
  input  logic [ROB_LEN_P-1:0]          tag_q,
  input  logic [DATA_W_P-1:0]           opd_q,
  input  logic                          rob_v,
  input  logic [DATA_W_P-1:0]           rob_d,
  input  cdb_lane_t [CDB_CNT-1:0]       lane,
  output logic                          v_fwd,
  output logic [DATA_W_P-1:0]           d_fwd,
  output logic                          v_out
);

  logic                cdb_hit;
  logic [DATA_W_P-1:0] cdb_d;

`ifdef WIRED_DISPATCH_CDB_BANKED_EN
  localparam int LB   = lane_bits(CDB_CNT);
  localparam int LSEL = (LB == 0) ? 1 : LB;
  logic [LSEL-1:0] sel;

  // Only the bank owning this tag can carry it, so the low tag bits are implied.
  always_comb begin
    sel     = LSEL'(lane_index(tag_q, CDB_CNT));
    cdb_hit = ~opv_q & lane[sel].valid & (((lane[sel].wid ^ tag_q) >> LB) == '0);
    cdb_d   = lane[sel].wdata;
  end
`else
  logic [CDB_CNT-1:0] hit;

  // Compare every lane; at most one may carry a given tag.
  always_comb begin
    hit   = '0;
    cdb_d = '0;
    for (int l = 0; l < CDB_CNT; l++) begin
      hit[l] = ~opv_q & lane[l].valid & (lane[l].wid == tag_q);
      if (hit[l]) cdb_d = lane[l].wdata;
    end
    cdb_hit = |hit;
  end

  a_one_lane: assert property (@(posedge clk) disable iff (!rst_n) live |-> $onehot0(hit));
`endif

  // CDB wins over ROB read data; an already-valid operand is left alone.
  always_comb begin
    v_fwd = opv_q;
    d_fwd = opd_q;
    if (cdb_hit) begin
      v_fwd = 1'b1;
      d_fwd = cdb_d;
    end else if (~opv_q & rob_v) begin
      v_fwd = 1'b1;
      d_fwd = rob_d;
    end
  end

  assign v_out = v_fwd & ~scyc_q;

endmodule

// File: rtl/wired_dispatch_stage.sv
// rtl/wired_dispatch_stage.sv - dispatch register with in-order prefix issue and late operand capture (option: WIRED_DISPATCH_CDB_BANKED_EN)
import wired_dispatch_pkg::*;

module wired_dispatch_stage #(
  parameter int WIDTH   = 2,
  parameter int CDB_CNT = 2,
  parameter int FU_CNT  = FU_CNT_P,
  parameter int ROB_LEN = ROB_LEN_P,
  parameter int DATA_W  = DATA_W_P
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  wired_dispatch_stage_if.slave  io
);

  logic [WIDTH-1:0]        mask_q;
  disp_slot_t              slot_q [WIDTH];
  logic [WIDTH-1:0]        issue;
  logic [WIDTH-1:0]        remain;
  logic                    load;
  cdb_lane_t [CDB_CNT-1:0] lanes;
  logic [2*WIDTH-1:0]      v_fwd;
  logic [2*WIDTH-1:0]      v_out;
  logic [DATA_W-1:0]       d_fwd [2*WIDTH];

  // Unpack CDB lanes into structs for the forwarding muxes.
  always_comb begin
    for (int l = 0; l < CDB_CNT; l++) begin
      lanes[l].valid = io.cdb_valid_i[l];
      lanes[l].wid   = io.cdb_wid_i[l*ROB_LEN +: ROB_LEN];
      lanes[l].wdata = io.cdb_wdata_i[l*DATA_W +: DATA_W];
    end
  end

  // Issue the longest in-order prefix of live slots whose target queue is ready.
  always_comb begin
    logic              chain;
    logic [FU_CNT-1:0] tgt;
    chain         = 1'b1;
    issue         = '0;
    io.fu_valid_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tgt      = slot_q[i].excp ? FU_CNT'(1 << FU_ALU) : slot_q[i].fu;
      issue[i] = chain & mask_q[i] & (|(tgt & io.fu_ready_i));
      chain    = chain & (~mask_q[i] | issue[i]);
      io.fu_valid_o[i*FU_CNT +: FU_CNT] = issue[i] ? tgt : '0;
    end
  end

  assign remain       = mask_q & ~issue;
  assign io.rob_we_o  = issue;
  assign io.r_ready_o = ~(|remain) & ~flush_i;
  assign load         = io.r_ready_o & (|io.r_valid_i);

  // Slot occupancy: flush beats load, load beats issue bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n)       mask_q <= '0;
    else if (flush_i) mask_q <= '0;
    else if (load)    mask_q <= io.r_valid_i;
    else              mask_q <= remain;
  end

  // Packet payload: capture from rename on load, otherwise fold in forwarded operands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        slot_q[i].fu   <= io.r_fu_i[i*FU_CNT +: FU_CNT];
        slot_q[i].excp <= io.r_excp_i[i];
        for (int j = 0; j < 2; j++) begin
          slot_q[i].tag[j]  <= io.r_tag_i[(2*i+j)*ROB_LEN +: ROB_LEN];
          slot_q[i].opv[j]  <= io.r_opv_i[2*i+j];
          slot_q[i].opd[j]  <= io.r_opd_i[(2*i+j)*DATA_W +: DATA_W];
          slot_q[i].scyc[j] <= io.r_scyc_i[2*i+j];
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          slot_q[i].opv[j] <= v_fwd[2*i+j];
          slot_q[i].opd[j] <= d_fwd[2*i+j];
        end
      end
    end
  end

  for (genvar k = 0; k < 2*WIDTH; k++) begin : g_fwd
    wired_dispatch_fwd #(.CDB_CNT(CDB_CNT)) u_fwd (
      .clk    (clk),
      .rst_n  (rst_n),
      .live   (mask_q[k/2]),
      .opv_q  (slot_q[k/2].opv[k%2]),
      .scyc_q (slot_q[k/2].scyc[k%2]),
      .tag_q  (slot_q[k/2].tag[k%2]),
      .opd_q  (slot_q[k/2].opd[k%2]),
      .rob_v  (io.rob_v_i[k]),
      .rob_d  (io.rob_d_i[k*DATA_W +: DATA_W]),
      .lane   (lanes),
      .v_fwd  (v_fwd[k]),
      .d_fwd  (d_fwd[k]),
      .v_out  (v_out[k])
    );
  end

  // Operand views are zero for empty slots so stale payload never leaks out.
  always_comb begin
    io.p_opv_o = '0;
    io.p_opd_o = '0;
    io.p_tag_o = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      if (mask_q[k/2]) begin
        io.p_opv_o[k]                       = v_out[k];
        io.p_opd_o[k*DATA_W +: DATA_W]      = d_fwd[k];
        io.p_tag_o[k*ROB_LEN +: ROB_LEN]    = slot_q[k/2].tag[k%2];
      end
    end
  end

endmodule

// File: tb/tb_wired_dispatch_stage.sv
// tb/tb_wired_dispatch_stage.sv - directed and randomized checks of the dispatch stage against a reference model
module tb_wired_dispatch_stage;

  localparam int W = 2, C = 2, F = 4, RL = 6, DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  wired_dispatch_stage_if #(.WIDTH(W), .CDB_CNT(C), .FU_CNT(F), .ROB_LEN(RL), .DATA_W(DW)) bus ();

  wired_dispatch_stage #(.WIDTH(W), .CDB_CNT(C), .FU_CNT(F), .ROB_LEN(RL), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .io      (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: one packet of W slots, two operands each.
  bit            m_mask [W];
  int            m_fu   [W];
  bit            m_excp [W];
  bit            m_opv  [2*W];
  bit            m_scyc [2*W];
  logic [DW-1:0] m_opd  [2*W];
  logic [RL-1:0] m_tag  [2*W];

  bit               e_ready;
  logic [W*F-1:0]   e_fuv;
  logic [W-1:0]     e_we;
  logic [2*W-1:0]   e_opv;
  logic [2*W*DW-1:0] e_opd;
  logic [2*W*RL-1:0] e_tag;
  bit               f_v [2*W];
  logic [DW-1:0]    f_d [2*W];

  function automatic void model_eval();
    bit go;
    bit left;
    int t;
    go = 1; left = 0;
    e_fuv = '0; e_we = '0; e_opv = '0; e_opd = '0; e_tag = '0;
    for (int i = 0; i < W; i++) begin
      if (m_mask[i]) begin
        t = m_excp[i] ? 0 : m_fu[i];
        if (go && bus.fu_ready_i[t]) begin
          e_fuv[i*F+t] = 1'b1;
          e_we[i] = 1'b1;
        end else begin
          go = 0;
          left = 1;
        end
      end
    end
    e_ready = !left && !flush;
    for (int k = 0; k < 2*W; k++) begin
      bit found;
      found = 0;
      f_v[k] = m_opv[k];
      f_d[k] = m_opd[k];
      if (!m_opv[k]) begin
        for (int l = 0; l < C; l++)
          if (bus.cdb_valid_i[l] && bus.cdb_wid_i[l*RL +: RL] == m_tag[k]) begin
            found = 1; f_v[k] = 1; f_d[k] = bus.cdb_wdata_i[l*DW +: DW];
          end
        if (!found && bus.rob_v_i[k]) begin
          f_v[k] = 1; f_d[k] = bus.rob_d_i[k*DW +: DW];
        end
      end
      if (m_mask[k/2]) begin
        e_opv[k] = f_v[k] & !m_scyc[k];
        e_opd[k*DW +: DW] = f_d[k];
        e_tag[k*RL +: RL] = m_tag[k];
      end
    end
  endfunction

  function automatic void model_commit();
    bit ld;
    ld = e_ready && (bus.r_valid_i != 0);
    for (int i = 0; i < W; i++) begin
      if (!rst_n || flush) m_mask[i] = 0;
      else if (ld) m_mask[i] = bus.r_valid_i[i];
      else if (e_we[i]) m_mask[i] = 0;
      if (ld) begin
        m_excp[i] = bus.r_excp_i[i];
        m_fu[i] = 0;
        for (int b = 0; b < F; b++) if (bus.r_fu_i[i*F+b]) m_fu[i] = b;
      end
    end
    for (int k = 0; k < 2*W; k++) begin
      if (ld) begin
        m_tag[k] = bus.r_tag_i[k*RL +: RL];
        m_opv[k] = bus.r_opv_i[k];
        m_opd[k] = bus.r_opd_i[k*DW +: DW];
        m_scyc[k] = bus.r_scyc_i[k];
      end else begin
        m_opv[k] = f_v[k];
        m_opd[k] = f_d[k];
      end
    end
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    flush = 1'b0;
    bus.r_valid_i = '0; bus.r_tag_i = '0; bus.r_opv_i = '0; bus.r_opd_i = '0;
    bus.r_scyc_i = '0; bus.r_fu_i = '0; bus.r_excp_i = '0;
    bus.rob_v_i = '0; bus.rob_d_i = '0;
    bus.cdb_valid_i = '0; bus.cdb_wid_i = '0; bus.cdb_wdata_i = '0;
    bus.fu_ready_i = '0;
  endtask

  task automatic set_slot(int i, logic [F-1:0] fu, bit excp, logic [RL-1:0] tag0, bit opv0, bit scyc0);
    bus.r_fu_i[i*F +: F] = fu;
    bus.r_excp_i[i] = excp;
    bus.r_tag_i[(2*i)*RL +: RL] = tag0;
    bus.r_opv_i[2*i] = opv0;
    bus.r_scyc_i[2*i] = scyc0;
    bus.r_opd_i[(2*i)*DW +: DW] = 32'h1000 + i;
    bus.r_tag_i[(2*i+1)*RL +: RL] = RL'(i + 20);
    bus.r_opv_i[2*i+1] = 1'b1;
    bus.r_scyc_i[2*i+1] = 1'b0;
    bus.r_opd_i[(2*i+1)*DW +: DW] = 32'h2000 + i;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    settle(); tick();
    settle(); tick();
    rst_n = 1'b1;
    settle();
    checks++;
    if (bus.r_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.r_ready_o); end
    checks++;
    if ({bus.fu_valid_o, bus.rob_we_o} !== '0) begin errors++; $display("FAIL reset_strobes got=%h exp=0", {bus.fu_valid_o, bus.rob_we_o}); end
    checks++;
    if ({bus.p_opv_o, bus.p_opd_o, bus.p_tag_o} !== '0) begin errors++; $display("FAIL reset_operands got=%h exp=0", {bus.p_opv_o, bus.p_opd_o, bus.p_tag_o}); end
  endtask

  task automatic test_full_issue();
    drive_idle();
    bus.fu_ready_i = 4'b1111;
    bus.r_valid_i = 2'b11;
    set_slot(0, 4'b0010, 0, 6'h01, 1, 0);
    set_slot(1, 4'b0100, 0, 6'h02, 1, 0);
    settle(); tick();
    set_slot(0, 4'b0001, 0, 6'h03, 1, 0);
    set_slot(1, 4'b1000, 0, 6'h04, 1, 0);
    settle();
    checks++;
    if (bus.fu_valid_o !== 8'b0100_0010) begin errors++; $display("FAIL full_fuv got=%b exp=01000010", bus.fu_valid_o); end
    checks++;
    if (bus.rob_we_o !== 2'b11) begin errors++; $display("FAIL full_we got=%b exp=11", bus.rob_we_o); end
    checks++;
    if (bus.r_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready got=%b exp=1", bus.r_ready_o); end
    tick();
    bus.r_valid_i = 2'b00;
    settle();
    checks++;
    if (bus.fu_valid_o !== 8'b1000_0001) begin errors++; $display("FAIL b2b_fuv got=%b exp=10000001", bus.fu_valid_o); end
    checks++;
    if (bus.p_tag_o[RL-1:0] !== 6'h03) begin errors++; $display("FAIL b2b_tag got=%h exp=03", bus.p_tag_o[RL-1:0]); end
    tick();
    settle();
    checks++;
    if (bus.rob_we_o !== 2'b00) begin errors++; $display("FAIL full_idle_we got=%b exp=00", bus.rob_we_o); end
    tick();
  endtask

  task automatic test_partial();
    drive_idle();
    bus.fu_ready_i = 4'b0010;
    bus.r_valid_i = 2'b11;
    set_slot(0, 4'b0010, 0, 6'h01, 1, 0);
    set_slot(1, 4'b0100, 0, 6'h02, 1, 0);
    settle(); tick();
    set_slot(0, 4'b0001, 0, 6'h09, 1, 0);
    set_slot(1, 4'b0001, 0, 6'h0a, 1, 0);
    settle();
    checks++;
    if (bus.fu_valid_o !== 8'b0000_0010) begin errors++; $display("FAIL part_fuv got=%b exp=00000010", bus.fu_valid_o); end
    checks++;
    if (bus.rob_we_o !== 2'b01 || bus.r_ready_o !== 1'b0) begin errors++; $display("FAIL part_we_ready got=%b/%b exp=01/0", bus.rob_we_o, bus.r_ready_o); end
    tick();
    settle();
    checks++;
    if (dut.mask_q !== 2'b10) begin errors++; $display("FAIL part_mask got=%b exp=10", dut.mask_q); end
    checks++;
    if (bus.rob_we_o !== 2'b00 || bus.r_ready_o !== 1'b0) begin errors++; $display("FAIL part_stall got=%b/%b exp=00/0", bus.rob_we_o, bus.r_ready_o); end
    tick();
    bus.r_valid_i = 2'b00;
    bus.fu_ready_i = 4'b0110;
    settle();
    checks++;
    if (bus.fu_valid_o !== 8'b0100_0000 || bus.rob_we_o !== 2'b10) begin errors++; $display("FAIL part_rest got=%b/%b exp=01000000/10", bus.fu_valid_o, bus.rob_we_o); end
    checks++;
    if (bus.r_ready_o !== 1'b1) begin errors++; $display("FAIL part_ready got=%b exp=1", bus.r_ready_o); end
    tick();
  endtask

  task automatic test_prefix_block();
    drive_idle();
    bus.fu_ready_i = 4'b0100;
    bus.r_valid_i = 2'b11;
    set_slot(0, 4'b0010, 0, 6'h01, 1, 0);
    set_slot(1, 4'b0100, 0, 6'h02, 1, 0);
    settle(); tick();
    bus.r_valid_i = 2'b00;
    settle();
    checks++;
    if (bus.fu_valid_o !== '0 || bus.rob_we_o !== 2'b00) begin errors++; $display("FAIL prefix_block got=%b/%b exp=0/00", bus.fu_valid_o, bus.rob_we_o); end
    tick();
    flush = 1'b1;
    settle(); tick();
    flush = 1'b0;
  endtask

  task automatic test_cdb_capture(bit scyc);
    drive_idle();
    bus.r_valid_i = 2'b01;
    set_slot(0, 4'b0010, 0, 6'h05, 0, scyc);
    settle(); tick();
    bus.r_valid_i = 2'b00;
    bus.cdb_valid_i = 2'b10;
    bus.cdb_wid_i = {6'h05, 6'h11};
    bus.cdb_wdata_i = {32'hDEADBEEF, 32'h0};
    settle(); tick();
    bus.cdb_valid_i = 2'b00;
    bus.cdb_wid_i = '0;
    bus.cdb_wdata_i = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (bus.p_opv_o[0] !== !scyc) begin errors++; $display("FAIL cdb_hold_v scyc=%0d got=%b exp=%b", scyc, bus.p_opv_o[0], !scyc); end
      if (!scyc) begin
        checks++;
        if (bus.p_opd_o[DW-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL cdb_hold_d got=%h exp=deadbeef", bus.p_opd_o[DW-1:0]); end
      end
      tick();
    end
    flush = 1'b1;
    settle();
    checks++;
    if (bus.r_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_low got=%b exp=0", bus.r_ready_o); end
    tick();
    flush = 1'b0;
  endtask

  task automatic test_excp();
    drive_idle();
    bus.fu_ready_i = 4'b1111;
    bus.r_valid_i = 2'b01;
    set_slot(0, 4'b1000, 1, 6'h07, 1, 0);
    settle(); tick();
    bus.r_valid_i = 2'b00;
    settle();
    checks++;
    if (bus.fu_valid_o !== 8'b0000_0001 || bus.rob_we_o !== 2'b01) begin errors++; $display("FAIL excp_alu got=%b/%b exp=00000001/01", bus.fu_valid_o, bus.rob_we_o); end
    tick();
  endtask

  task automatic test_flush_partial();
    drive_idle();
    bus.fu_ready_i = 4'b0010;
    bus.r_valid_i = 2'b11;
    set_slot(0, 4'b0010, 0, 6'h01, 1, 0);
    set_slot(1, 4'b0100, 0, 6'h02, 1, 0);
    settle(); tick();
    bus.r_valid_i = 2'b00;
    flush = 1'b1;
    settle();
    checks++;
    if (bus.rob_we_o !== 2'b01 || bus.r_ready_o !== 1'b0) begin errors++; $display("FAIL flush_cycle got=%b/%b exp=01/0", bus.rob_we_o, bus.r_ready_o); end
    tick();
    flush = 1'b0;
    bus.fu_ready_i = 4'b1111;
    settle();
    checks++;
    if (dut.mask_q !== 2'b00 || bus.r_ready_o !== 1'b1) begin errors++; $display("FAIL flush_after got=%b/%b exp=00/1", dut.mask_q, bus.r_ready_o); end
    checks++;
    if (bus.fu_valid_o !== '0 || bus.rob_we_o !== 2'b00) begin errors++; $display("FAIL flush_nostrobe got=%b/%b exp=0/00", bus.fu_valid_o, bus.rob_we_o); end
    tick();
  endtask

  task automatic test_mid_reset();
    drive_idle();
    bus.r_valid_i = 2'b11;
    set_slot(0, 4'b0010, 0, 6'h01, 1, 0);
    set_slot(1, 4'b0100, 0, 6'h02, 1, 0);
    settle(); tick();
    bus.r_valid_i = 2'b00;
    rst_n = 1'b0;
    settle(); tick();
    rst_n = 1'b1;
    bus.fu_ready_i = 4'b1111;
    settle();
    checks++;
    if (bus.rob_we_o !== 2'b00 || bus.fu_valid_o !== '0 || bus.r_ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset got=%b/%b/%b exp=00/0/1", bus.rob_we_o, bus.fu_valid_o, bus.r_ready_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [RL-1:0] w0;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(63) != 0);
      flush = ($urandom_range(15) == 0);
      bus.r_valid_i = 2'($urandom);
      for (int i = 0; i < W; i++) begin
        bus.r_fu_i[i*F +: F] = 4'(1 << $urandom_range(F-1));
        bus.r_excp_i[i] = ($urandom_range(7) == 0);
      end
      bus.r_tag_i = 24'($urandom);
      bus.r_opv_i = 4'($urandom);
      bus.r_opd_i = {$urandom, $urandom, $urandom, $urandom};
      bus.r_scyc_i = 4'($urandom) & 4'($urandom);
      bus.rob_v_i = 4'($urandom) & 4'($urandom);
      bus.rob_d_i = {$urandom, $urandom, $urandom, $urandom};
      bus.cdb_valid_i = 2'($urandom);
      w0 = $urandom_range(1) ? m_tag[$urandom_range(2*W-1)] : RL'($urandom);
      if ($urandom_range(1)) bus.cdb_wid_i = {w0 ^ RL'($urandom_range(63, 1)), w0};
      else bus.cdb_wid_i = {w0, w0 ^ RL'($urandom_range(63, 1))};
      bus.cdb_wdata_i = {$urandom, $urandom};
      bus.fu_ready_i = 4'($urandom);
      settle();
      checks++;
      if (bus.r_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.r_ready_o, e_ready); end
      checks++;
      if (bus.fu_valid_o !== e_fuv) begin errors++; $display("FAIL rnd_fuv c=%0d got=%b exp=%b", c, bus.fu_valid_o, e_fuv); end
      checks++;
      if (bus.rob_we_o !== e_we) begin errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, bus.rob_we_o, e_we); end
      checks++;
      if (bus.p_opv_o !== e_opv) begin errors++; $display("FAIL rnd_opv c=%0d got=%b exp=%b", c, bus.p_opv_o, e_opv); end
      checks++;
      if (bus.p_opd_o !== e_opd) begin errors++; $display("FAIL rnd_opd c=%0d got=%h exp=%h", c, bus.p_opd_o, e_opd); end
      checks++;
      if (bus.p_tag_o !== e_tag) begin errors++; $display("FAIL rnd_tag c=%0d got=%h exp=%h", c, bus.p_tag_o, e_tag); end
      tick();
    end
    rst_n = 1'b1;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    test_reset();
    test_full_issue();
    test_partial();
    test_prefix_block();
    test_cdb_capture(1'b0);
    test_cdb_capture(1'b1);
    test_excp();
    test_flush_partial();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
